// File: rtl/push_evt_arb.sv
// rtl/push_evt_arb.sv - button press event arbiter; macro PUSH_ARB_PRIO_EN selects fixed priority instead of round-robin
`ifndef CNT_LEN
`define CNT_LEN 8
`endif

module push_evt_arb #(
  parameter int N_BTN  = 4,
  parameter int ID_W   = 2,
  parameter int PEND_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [N_BTN-1:0]     i_press,
  output logic                 o_evt_valid,
  output logic [ID_W-1:0]      o_evt_id,
  input  logic                 i_evt_ready,
  output logic [N_BTN-1:0]     o_ovf,
  input  logic                 i_ovf_clr,
  output logic [`CNT_LEN-1:0]  o_evt_total,
  output logic                 o_busy
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PEND_W-1:0]   r_pend [N_BTN];
  logic [N_BTN-1:0]    r_ovf;
  logic [ID_W-1:0]     r_evt_id;
  logic [`CNT_LEN-1:0] r_total;

  logic [N_BTN-1:0]    w_nz;
  logic [N_BTN-1:0]    w_inc;
  logic [N_BTN-1:0]    w_dec;
  logic [N_BTN-1:0]    w_ovf_set;
  logic                w_win_found;
  logic [ID_W-1:0]     w_win_id;
  logic                w_grant;
  logic                w_hs;

  // Per-button request/grant decode: a press only counts while enabled,
  // and only the selected winner is decremented when a grant happens.
  for (genvar gb = 0; gb < N_BTN; gb++) begin : g_btn
    assign w_nz[gb]      = |r_pend[gb];
    assign w_inc[gb]     = i_en & i_press[gb];
    assign w_dec[gb]     = w_grant && (w_win_id == ID_W'(gb));
    assign w_ovf_set[gb] = w_inc[gb] & ~w_dec[gb] & (r_pend[gb] == PEND_MAX);
  end

`ifdef PUSH_ARB_PRIO_EN
  // Fixed priority: lowest-index button with pending events wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_nz[i]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0]      r_rr;
  logic [2*N_BTN-1:0]   w_rot;
  int                   w_idx;

  // Rotating the doubled request vector by rr turns the wrapped scan into
  // a plain lowest-bit search.
  assign w_rot = {w_nz, w_nz} >> r_rr;

  // Round-robin search starting at rr, wrapping at N_BTN-1.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = 0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!w_win_found && w_rot[k]) begin
        w_win_found = 1'b1;
        w_idx       = int'(r_rr) + k;
        if (w_idx >= N_BTN) begin
          w_idx = w_idx - N_BTN;
        end
        w_win_id = ID_W'(w_idx);
      end
    end
  end

  // Pointer moves just past the button whose event was accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr <= '0;
    end else if (w_hs) begin
      r_rr <= (r_evt_id == ID_W'(N_BTN - 1)) ? '0 : r_evt_id + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant from IDLE when anything is pending, leave PRESENT on handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_evt_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Event id is captured at grant and held through PRESENT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_evt_id <= '0;
    end else if (w_grant) begin
      r_evt_id <= w_win_id;
    end
  end

  // Delivered-event counter, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_total <= '0;
    end else if (w_hs) begin
      r_total <= r_total + 1'b1;
    end
  end

  // Pending counters: saturating increment on press, decrement on grant,
  // both together leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < N_BTN; b++) begin
        r_pend[b] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BTN; b++) begin
        if (w_inc[b] && !w_dec[b]) begin
          if (r_pend[b] != PEND_MAX) begin
            r_pend[b] <= r_pend[b] + 1'b1;
          end
        end else if (!w_inc[b] && w_dec[b]) begin
          r_pend[b] <= r_pend[b] - 1'b1;
        end
      end
    end
  end

  // Sticky overflow flags; a new loss on the clearing edge stays visible.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~{N_BTN{i_ovf_clr}}) | w_ovf_set;
    end
  end

  assign o_evt_valid = (r_state == ST_PRESENT);
  assign o_evt_id    = r_evt_id;
  assign o_ovf       = r_ovf;
  assign o_evt_total = r_total;
  assign o_busy      = (r_state != ST_IDLE) | (|w_nz);

  // An offered event must stay put until it is taken.
  a_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_evt_valid && !i_evt_ready) |=> (o_evt_valid && $stable(o_evt_id)));

  // Only real button indices are ever presented.
  a_id_range: assert property (@(posedge i_clk) disable iff (i_rst)
    o_evt_valid |-> (int'(o_evt_id) < N_BTN));

endmodule

// File: tb/tb_push_evt_arb.sv
// tb/tb_push_evt_arb.sv - randomized self-checking bench for push_evt_arb against a behavioural model
`ifndef CNT_LEN
`define CNT_LEN 8
`endif

module tb_push_evt_arb;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int PW   = 3;
  localparam int CW   = `CNT_LEN;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  press;
  logic          ready;
  logic          ovf_clr;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic [N-1:0]  ovf;
  logic [CW-1:0] evt_total;
  logic          busy;

  push_evt_arb #(.N_BTN(N), .ID_W(IW), .PEND_W(PW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_press     (press),
    .o_evt_valid (evt_valid),
    .o_evt_id    (evt_id),
    .i_evt_ready (ready),
    .o_ovf       (ovf),
    .i_ovf_clr   (ovf_clr),
    .o_evt_total (evt_total),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: queued press counts, the event on offer, history pointer.
  int m_pend [N];
  bit m_pres;
  int m_id;
  int m_rr;
  int m_total;
  int m_ovf;
  int m_delivered;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [N-1:0] p,
                            input bit rd, input bit c);
    int grant;
    int b;
    int set_mask;
    bit hs;
    bit inc;
    bit dec;
    if (r) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_pres  = 0;
      m_id    = 0;
      m_rr    = 0;
      m_total = 0;
      m_ovf   = 0;
      return;
    end
    grant = -1;
    if (!m_pres) begin
      for (int i = 0; i < N; i++) begin
`ifdef PUSH_ARB_PRIO_EN
        b = i;
`else
        b = (m_rr + i) % N;
`endif
        if (grant < 0 && m_pend[b] > 0) grant = b;
      end
    end
    hs = m_pres && rd;
    set_mask = 0;
    for (int i = 0; i < N; i++) begin
      inc = e && p[i];
      dec = (i == grant);
      if (inc && !dec) begin
        if (m_pend[i] == PMAX) set_mask |= (1 << i);
        else m_pend[i]++;
      end else if (dec && !inc) begin
        m_pend[i]--;
      end
    end
    m_ovf = (c ? 0 : m_ovf) | set_mask;
    if (grant >= 0) begin
      m_pres = 1;
      m_id   = grant;
    end else if (hs) begin
      m_pres  = 0;
      m_total = (m_total + 1) % (1 << CW);
      m_rr    = (m_id + 1) % N;
      m_delivered++;
    end
  endtask

  task automatic compare_all();
    int any;
    any = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] > 0) any = 1;
    check("valid", int'(evt_valid), int'(m_pres));
    check("id",    int'(evt_id),    m_id);
    check("ovf",   int'(ovf),       m_ovf);
    check("total", int'(evt_total), m_total);
    check("busy",  int'(busy),      (m_pres || any) ? 1 : 0);
  endtask

  task automatic cycle(input bit r, input bit e, input logic [N-1:0] p,
                       input bit rd, input bit c);
    rst = r; en = e; press = p; ready = rd; ovf_clr = c;
    @(posedge clk);
    model_step(r, e, p, rd, c);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0, rd, 1'b0);
  endtask

  int start_cnt;
  bit slow_ready;

  initial begin
    m_delivered = 0;
    rst = 1'b1; en = 1'b0; press = '0; ready = 1'b0; ovf_clr = 1'b0;

    // reset
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // single press held off by ready, then accepted
    cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
    idle(6, 1'b0);
    check("single_id", int'(evt_id), 2);
    idle(3, 1'b1);
    check("single_total", int'(evt_total), 1);
    check("single_busy", int'(busy), 0);

    // all buttons at once, twice, ready tied high
    cycle(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
    idle(9, 1'b1);
    cycle(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
    idle(9, 1'b1);
    check("burst_total", int'(evt_total), 9);

    // saturation on button 1, drain, then clear the flag
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
    check("sat_ovf", int'(ovf), 4'b0010);
    start_cnt = m_delivered;
    idle(24, 1'b1);
    check("sat_drain", m_delivered - start_cnt, 8);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);
    check("sat_clr", int'(ovf), 0);

    // clear and overflow on the same edge: the new overflow survives
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);
    check("clr_vs_set", int'(ovf), 4'b0001);
    idle(20, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);

    // press coinciding with grant on button 3
    cycle(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
    start_cnt = m_delivered;
    idle(6, 1'b1);
    check("same_edge_events", m_delivered - start_cnt, 2);

    // presses ignored while disabled
    cycle(1'b0, 1'b0, 4'b0011, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("dis_busy", int'(busy), 0);
    start_cnt = m_delivered;
    cycle(1'b0, 1'b1, 4'b0011, 1'b1, 1'b0);
    idle(6, 1'b1);
    check("en_events", m_delivered - start_cnt, 2);

    // reset while presenting with three buttons pending
    cycle(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_total", int'(evt_total), 0);

    // randomized traffic with phases of slow consumer
    slow_ready = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) slow_ready = ($urandom_range(0, 1) == 1);
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 7) != 0),
            N'($urandom & $urandom),
            slow_ready ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 40) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
